// File: rtl/param_equalizer.sv
// param_equalizer: N-band equaliser built from a bank of leaky integrators, three-stage
// valid/ready pipeline. Define EQ_SAT_EN for output saturation with a sticky clip flag.
module param_equalizer #(
   parameter int DATA_W    = 16,
   parameter int N_BANDS   = 3,
   parameter int GAIN_W    = 8,
   parameter int GAIN_FRAC = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_BANDS*GAIN_W-1:0]   gain_in,
   input  logic                        gain_load,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        clip
);

   localparam int LW     = DATA_W + 2;
   // Integrator states never leave the input range, so a band difference fits in DATA_W+1 bits.
   localparam int BAND_W = DATA_W + 1;
   localparam int PROD_W = GAIN_W + BAND_W;
   localparam int ACC_W  = DATA_W + GAIN_W + $clog2(N_BANDS) + 2;
   localparam logic [GAIN_W-1:0]         UNITY     = GAIN_W'(1) << GAIN_FRAC;
   localparam logic [N_BANDS*GAIN_W-1:0] UNITY_ALL = {N_BANDS{UNITY}};

   logic                     adv;
   logic                     accept;
   logic signed [LW-1:0]     lstate   [1:N_BANDS-1];
   logic signed [LW-1:0]     ltap     [N_BANDS];
   logic signed [BAND_W-1:0] band_nxt [N_BANDS];
   logic signed [BAND_W-1:0] s1_band  [N_BANDS];
   logic [N_BANDS*GAIN_W-1:0] shadow_gain;
   logic [N_BANDS*GAIN_W-1:0] active_gain;
   logic                     s1_valid;
   logic [PROD_W-1:0]        prod_nxt [N_BANDS];
   logic signed [PROD_W-1:0] s2_prod  [N_BANDS];
   logic                     s2_valid;
   logic signed [ACC_W-1:0]  acc;
   logic [DATA_W-1:0]        result;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && adv;

   // Band split: tap 0 is the raw sample, bands are differences of adjacent pre-update taps.
   always_comb begin
      ltap[0] = {{2{in_data[DATA_W-1]}}, in_data};
      for (int k = 1; k < N_BANDS; k++) ltap[k] = lstate[k];
      for (int j = 0; j < N_BANDS-1; j++) band_nxt[j] = BAND_W'(ltap[j] - ltap[j+1]);
      band_nxt[N_BANDS-1] = BAND_W'(ltap[N_BANDS-1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k < N_BANDS; k++) lstate[k] <= '0;
      end else if (accept) begin
         for (int k = 1; k < N_BANDS; k++) lstate[k] <= lstate[k] + ((ltap[0] - lstate[k]) >>> k);
      end
   end

   // The active gains travel with the sample in S1; a pending shadow load takes effect on the next accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid    <= 1'b0;
         shadow_gain <= UNITY_ALL;
         active_gain <= UNITY_ALL;
         for (int j = 0; j < N_BANDS; j++) s1_band[j] <= '0;
      end else begin
         if (gain_load) shadow_gain <= gain_in;
         if (accept) active_gain <= shadow_gain;
         if (adv) begin
            s1_valid <= in_valid;
            for (int j = 0; j < N_BANDS; j++) s1_band[j] <= band_nxt[j];
         end
      end
   end

   // Operands are sign-extended to the product width so an unsigned multiply yields the exact signed product.
   always_comb begin
      for (int j = 0; j < N_BANDS; j++) begin
         prod_nxt[j] = {{BAND_W{active_gain[j*GAIN_W+GAIN_W-1]}}, active_gain[j*GAIN_W +: GAIN_W]}
                     * {{GAIN_W{s1_band[j][BAND_W-1]}}, s1_band[j]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         for (int j = 0; j < N_BANDS; j++) s2_prod[j] <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         for (int j = 0; j < N_BANDS; j++) s2_prod[j] <= prod_nxt[j];
      end
   end

   always_comb begin
      acc = '0;
      for (int j = 0; j < N_BANDS; j++) begin
         acc = acc + {{(ACC_W-PROD_W){s2_prod[j][PROD_W-1]}}, s2_prod[j]};
      end
   end

`ifdef EQ_SAT_EN
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [ACC_W-1:0] scaled;
   logic                    res_clip;
   logic                    clip_q;

   always_comb begin
      scaled   = acc >>> GAIN_FRAC;
      result   = scaled[DATA_W-1:0];
      res_clip = 1'b0;
      if (scaled > MAXV) begin
         result   = {1'b0, {(DATA_W-1){1'b1}}};
         res_clip = 1'b1;
      end else if (scaled < MINV) begin
         result   = {1'b1, {(DATA_W-1){1'b0}}};
         res_clip = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) clip_q <= 1'b0;
      else if (adv && s2_valid && res_clip) clip_q <= 1'b1;
   end

   assign clip = clip_q;
`else
   assign result = DATA_W'(acc >>> GAIN_FRAC);
   assign clip   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         if (s2_valid) out_data <= result;
      end
   end

endmodule

// File: tb/tb_param_equalizer.sv
// tb_param_equalizer: table-driven and randomised checks of param_equalizer against a
// sample-level reference model; expectations follow EQ_SAT_EN when it is defined.
module tb_param_equalizer;

   localparam int DATA_W    = 16;
   localparam int N_BANDS   = 3;
   localparam int GAIN_W    = 8;
   localparam int GAIN_FRAC = 4;
   localparam int GV_W      = N_BANDS*GAIN_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [GV_W-1:0]   gain_in = '0;
   logic              gain_load = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              clip;

   always #5 clk = ~clk;

   param_equalizer #(.DATA_W(DATA_W), .N_BANDS(N_BANDS), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .gain_in(gain_in), .gain_load(gain_load), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .clip(clip)
   );

   typedef struct { int val; bit sat; } exp_t;
   typedef struct {
      string           name;
      logic [GV_W-1:0] gains;
      int              x;
      int              count;
      int              firstExp;
      int              lo;
      int              hi;
      bit              clipExp;
   } vec_t;

   exp_t            expq[$];
   longint          lModel[N_BANDS];
   logic [GV_W-1:0] mShadow;
   bit              clipModel;
   bit              holdPending;
   logic [DATA_W-1:0] heldData;
   int              checks = 0;
   int              errors = 0;
   int              outCount = 0;
   int              firstOut = 0;
   int              lastOut = 0;
   vec_t            vecs[7];

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic checkRange(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected range [%0d,%0d]", name, act, lo, hi);
      end
   endtask

   function automatic logic [GV_W-1:0] allg(input int g);
      logic [GV_W-1:0] r;
      for (int j = 0; j < N_BANDS; j++) r[j*GAIN_W +: GAIN_W] = GAIN_W'(g);
      return r;
   endfunction

   function automatic longint gainOf(input logic [GV_W-1:0] g, input int j);
      logic signed [GAIN_W-1:0] s;
      s = g[j*GAIN_W +: GAIN_W];
      return longint'(s);
   endfunction

   function automatic void modelReset();
      expq.delete();
      for (int k = 0; k < N_BANDS; k++) lModel[k] = 0;
      mShadow     = allg(1 << GAIN_FRAC);
      clipModel   = 1'b0;
      holdPending = 1'b0;
      outCount    = 0;
   endfunction

   // One accepted sample: weighted band sum, scale, limit, then advance the integrators.
   function automatic void modelAccept(input int x);
      longint acc;
      longint y;
      longint tap;
      longint band;
      exp_t   e;
      logic signed [DATA_W-1:0] w;
      acc = 0;
      for (int j = 0; j < N_BANDS; j++) begin
         tap = (j == 0) ? longint'(x) : lModel[j];
         if (j < N_BANDS-1) band = tap - lModel[j+1];
         else band = tap;
         acc += gainOf(mShadow, j) * band;
      end
      y = acc >>> GAIN_FRAC;
`ifdef EQ_SAT_EN
      if (y > 32767) begin e.val = 32767; e.sat = 1'b1; end
      else if (y < -32768) begin e.val = -32768; e.sat = 1'b1; end
      else begin e.val = int'(y); e.sat = 1'b0; end
`else
      w = y[DATA_W-1:0];
      e.val = int'(w);
      e.sat = 1'b0;
`endif
      expq.push_back(e);
      for (int k = 1; k < N_BANDS; k++) lModel[k] = lModel[k] + ((longint'(x) - lModel[k]) >>> k);
   endfunction

   // Monitor: observes the handshakes mid-cycle, so they match what the next rising edge commits.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         modelReset();
      end else begin
         if (holdPending) checkOutput("hold_data", longint'($signed(out_data)), longint'($signed(heldData)));
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               checkOutput("unexpected_out_valid", longint'(out_valid), 0);
            end else begin
               e = expq.pop_front();
               checkOutput("out_data", longint'($signed(out_data)), longint'(e.val));
               clipModel = clipModel | e.sat;
               checkOutput("clip", longint'(clip), longint'(clipModel));
               if (outCount == 0) firstOut = int'($signed(out_data));
               lastOut = int'($signed(out_data));
               outCount++;
            end
         end
         holdPending = out_valid && !out_ready;
         heldData    = out_data;
         checkOutput("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
         if (in_valid && in_ready) modelAccept(int'($signed(in_data)));
         if (gain_load) mShadow = gain_in;
      end
   end

   task automatic applyStimulus(input logic v, input int x, input logic rdy, input logic ld,
                                input logic [GV_W-1:0] g);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = DATA_W'(x);
      out_ready = rdy;
      gain_load = ld;
      gain_in   = g;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      reset = 1'b1; in_valid = 1'b0; gain_load = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_out_valid", longint'(out_valid), 0);
      checkOutput("reset_out_data", longint'($signed(out_data)), 0);
      checkOutput("reset_clip", longint'(clip), 0);
      checkOutput("reset_in_ready", longint'(in_ready), 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      applyStimulus(1'b0, 0, 1'b1, 1'b0, '0);
      while (expq.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      checkOutput("drain_empty", longint'(expq.size()), 0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int idx;
      int x;
      bit stall;
      logic [GV_W-1:0] g;

      vecs[0] = '{"unity100",  allg(16), 100,   10,  100,   100,   100,   1'b0};
      vecs[1] = '{"zero5000",  allg(0),  5000,  20,  0,     0,     0,     1'b0};
      vecs[2] = '{"lowband32", 24'h200000, 1000, 200, 0,    1984,  2000,  1'b0};
      vecs[3] = '{"unityNeg",  allg(16), -1234, 10,  -1234, -1234, -1234, 1'b0};
      vecs[4] = '{"double",    allg(32), 1000,  8,   2000,  2000,  2000,  1'b0};
`ifdef EQ_SAT_EN
      vecs[5] = '{"satPos",    allg(32), 30000, 8,   32767, 32767, 32767, 1'b1};
      vecs[6] = '{"satNeg",    allg(32), -30000, 8,  -32768, -32768, -32768, 1'b1};
`else
      vecs[5] = '{"wrapPos",   allg(32), 30000, 8,   -5536, -5536, -5536, 1'b0};
      vecs[6] = '{"wrapNeg",   allg(32), -30000, 8,  5536,  5536,  5536,  1'b0};
`endif

      repeat (2) @(posedge clk);

      for (int v = 0; v < 7; v++) begin
         doReset();
         applyStimulus(1'b0, 0, 1'b1, 1'b1, vecs[v].gains);
         for (int i = 0; i < vecs[v].count; i++) applyStimulus(1'b1, vecs[v].x, 1'b1, 1'b0, '0);
         drain();
         checkOutput({vecs[v].name, "_count"}, longint'(outCount), longint'(vecs[v].count));
         checkOutput({vecs[v].name, "_first"}, longint'(firstOut), longint'(vecs[v].firstExp));
         checkRange({vecs[v].name, "_last"}, longint'(lastOut), longint'(vecs[v].lo), longint'(vecs[v].hi));
         checkOutput({vecs[v].name, "_clip"}, longint'(clip), longint'(vecs[v].clipExp));
      end

      // Clip must survive a return to silence.
      doReset();
      applyStimulus(1'b0, 0, 1'b1, 1'b1, allg(32));
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 30000, 1'b1, 1'b0, '0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 0, 1'b1, 1'b0, '0);
      drain();
      checkOutput("sticky_last", longint'(lastOut), 0);
`ifdef EQ_SAT_EN
      checkOutput("sticky_clip", longint'(clip), 1);
`else
      checkOutput("sticky_clip", longint'(clip), 0);
`endif

      // Five-cycle downstream stall in a continuous stream; the source re-presents the held sample.
      doReset();
      idx = 0;
      for (int c = 0; c < 25; c++) begin
         stall = (c >= 8 && c < 13);
         applyStimulus(1'b1, idx*37 - 200, !stall, 1'b0, '0);
         if (stall) begin
            @(negedge clk);
            checkOutput("stall_in_ready", longint'(in_ready), 0);
         end else begin
            idx++;
         end
      end
      drain();
      checkOutput("stall_count", longint'(outCount), longint'(idx));
      checkOutput("stall_last", longint'(lastOut), longint'((idx-1)*37 - 200));

      // Gain change lands on the same cycle as an accept: that sample still uses unity.
      doReset();
      applyStimulus(1'b1, 100, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, 100, 1'b1, 1'b1, allg(0));
      applyStimulus(1'b1, 100, 1'b1, 1'b0, '0);
      drain();
      checkOutput("late_load_count", longint'(outCount), 3);
      checkOutput("late_load_last", longint'(lastOut), 0);

      // Reset while three samples are in flight and downstream is stalled.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 500, 1'b1, 1'b0, '0);
      @(posedge clk);
      #1;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("flight_out_valid", longint'(out_valid), 0);
      checkOutput("flight_in_ready", longint'(in_ready), 1);
      applyStimulus(1'b1, 100, 1'b1, 1'b0, '0);
      drain();
      checkOutput("flight_count", longint'(outCount), 1);
      checkOutput("flight_value", longint'(lastOut), 100);

      // Randomised traffic, back-pressure and gain reloads.
      doReset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom % 2 == 1) x = int'($signed(16'($urandom)));
         else x = int'($urandom_range(0, 600)) - 300;
         g = ($urandom % 2 == 1) ? GV_W'($urandom) : allg(16);
         applyStimulus(($urandom % 4) != 0, x, ($urandom % 3) != 0, ($urandom % 25) == 0, g);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
